// File: rtl/vram_rect_writer_pkg.sv
// Shared VRAM geometry, command field widths and writer state encoding.
// Imported by the rectangle writer, its command interface and benches.
package vram_rect_writer_pkg;

  localparam int VRAM_SCREEN_WIDTH  = 640;
  localparam int VRAM_SCREEN_HEIGHT = 480;
  localparam int VRAM_ADDR_WIDTH    = 19;
  localparam int VRAM_DATA_WIDTH    = 6;

  localparam int CMD_X_W = 10;
  localparam int CMD_Y_W = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

  // Sums arrive one bit wider than the operands, so no wrap.
  function automatic logic [CMD_X_W:0] clip_end(
    input logic [CMD_X_W:0] sum,
    input logic [CMD_X_W:0] lim
  );
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/vram_rect_writer_if.sv
// Rectangle-fill command handshake bundle.
// master issues commands, slave is the writer.
interface vram_rect_writer_if
  import vram_rect_writer_pkg::*;
#(
  parameter int DATA_WIDTH = VRAM_DATA_WIDTH
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [CMD_X_W-1:0]    cmd_x;
  logic [CMD_Y_W-1:0]    cmd_y;
  logic [CMD_X_W-1:0]    cmd_w;
  logic [CMD_Y_W-1:0]    cmd_h;
  logic [DATA_WIDTH-1:0] cmd_color;

  modport master (
    output cmd_valid,
    output cmd_x,
    output cmd_y,
    output cmd_w,
    output cmd_h,
    output cmd_color,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_x,
    input  cmd_y,
    input  cmd_w,
    input  cmd_h,
    input  cmd_color,
    output cmd_ready
  );

endinterface

// File: rtl/vram_rect_writer.sv
// Fills a clipped rectangle of VRAM with one palette index,
// one pixel per unpaused cycle, row-major order.
module vram_rect_writer
  import vram_rect_writer_pkg::*;
#(
  parameter int SCREEN_WIDTH  = VRAM_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = VRAM_SCREEN_HEIGHT,
  parameter int ADDR_WIDTH    = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH    = VRAM_DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  vram_rect_writer_if.slave     cmd,
  input  logic                  pause,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_write,
  output logic                  busy,
  output logic                  done
);

  localparam logic [CMD_X_W:0] SW =
    (CMD_X_W+1)'(SCREEN_WIDTH);
  localparam logic [CMD_Y_W:0] SH =
    (CMD_Y_W+1)'(SCREEN_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP =
    ADDR_WIDTH'(SCREEN_WIDTH);

  wr_state_e             state_q, state_d;
  logic [CMD_X_W-1:0]    x_q, x_d;
  logic [CMD_Y_W-1:0]    y_q, y_d;
  logic [CMD_X_W-1:0]    x_start_q, x_start_d;
  logic [CMD_X_W:0]      x_end_q, x_end_d;
  logic [CMD_Y_W:0]      y_end_q, y_end_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;

  logic [CMD_X_W:0]      x_sum, x_nxt;
  logic [CMD_Y_W:0]      y_sum, y_nxt;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] next_row;

  assign x_sum = {1'b0, cmd.cmd_x} + {1'b0, cmd.cmd_w};
  assign y_sum = {1'b0, cmd.cmd_y} + {1'b0, cmd.cmd_h};
  assign x_nxt = {1'b0, x_q} + 1'b1;
  assign y_nxt = {1'b0, y_q} + 1'b1;
  assign next_row = row_base_q + ROW_STEP;

  assign empty = (cmd.cmd_w == '0)
              || (cmd.cmd_h == '0)
              || ({1'b0, cmd.cmd_x} >= SW)
              || ({1'b0, cmd.cmd_y} >= SH);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    x_start_d  = x_start_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          x_d        = cmd.cmd_x;
          y_d        = cmd.cmd_y;
          x_start_d  = cmd.cmd_x;
          x_end_d    = clip_end(x_sum, SW);
          y_end_d    = clip_end(y_sum, SH);
          data_d     = cmd.cmd_color;
          // One multiply per command; per-pixel stepping is adds only.
          row_base_d = ADDR_WIDTH'(cmd.cmd_y) * ROW_STEP;
          addr_d     = row_base_d + ADDR_WIDTH'(cmd.cmd_x);
          if (empty) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (!pause) begin
          if (x_nxt != x_end_q) begin
            x_d    = x_nxt[CMD_X_W-1:0];
            addr_d = addr_q + 1'b1;
          end else if (y_nxt != y_end_q) begin
            x_d        = x_start_q;
            y_d        = y_nxt[CMD_Y_W-1:0];
            row_base_d = next_row;
            addr_d     = next_row + ADDR_WIDTH'(x_start_q);
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      x_start_q  <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      x_start_q  <= x_start_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  // Pause gates the strobe in the same cycle the reader claims the port.
  assign o_write       = (state_q == ST_FILL) && !pause;
  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign o_addr        = addr_q;
  assign o_data        = data_q;

endmodule

// File: tb/tb_vram_rect_writer.sv
// Directed bench for vram_rect_writer: fills, clipping,
// empty commands, pause, reset abort and back-to-back commands.
module tb_vram_rect_writer;
  import vram_rect_writer_pkg::*;

  logic        CLK;
  logic        RST_N;
  logic        pause;
  logic [18:0] o_addr;
  logic [5:0]  o_data;
  logic        o_write;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  int wr_addr[$];
  int wr_data[$];
  int done_cyc;

  vram_rect_writer_if #(.DATA_WIDTH(6)) cmd_if();

  vram_rect_writer dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .cmd     (cmd_if),
    .pause   (pause),
    .o_addr  (o_addr),
    .o_data  (o_data),
    .o_write (o_write),
    .busy    (busy),
    .done    (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input int x, input int y,
                      input int w, input int h,
                      input int c);
    int n = 0;
    while (!cmd_if.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_before_send", 32'(cmd_if.cmd_ready), 1);
    cmd_if.cmd_x     = 10'(x);
    cmd_if.cmd_y     = 9'(y);
    cmd_if.cmd_w     = 10'(w);
    cmd_if.cmd_h     = 9'(h);
    cmd_if.cmd_color = 6'(c);
    cmd_if.cmd_valid = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the accepting edge.
  task automatic collect(input int budget);
    wr_addr.delete();
    wr_data.delete();
    done_cyc = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (o_write) begin
        wr_addr.push_back(int'(o_addr));
        wr_data.push_back(int'(o_data));
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int exp_a[6];
    RST_N            = 1'b0;
    pause            = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_x     = '0;
    cmd_if.cmd_y     = '0;
    cmd_if.cmd_w     = '0;
    cmd_if.cmd_h     = '0;
    cmd_if.cmd_color = '0;
    tick();
    tick();
    chk("rst_write", 32'(o_write), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_data", 32'(o_data), 0);
    RST_N = 1'b1;
    tick();
    chk("rst_ready", 32'(cmd_if.cmd_ready), 1);

    // Basic 3x2 fill at (10,20)
    exp_a = '{12810, 12811, 12812, 13450, 13451, 13452};
    send(10, 20, 3, 2, 5);
    chk("fill_busy", 32'(busy), 1);
    chk("fill_ready", 32'(cmd_if.cmd_ready), 0);
    collect(40);
    chk("fill_count", 32'(wr_addr.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wr_addr.size()) begin
        chk("fill_addr", 32'(wr_addr[i]), 32'(exp_a[i]));
        chk("fill_data", 32'(wr_data[i]), 5);
      end
    end
    chk("fill_done_cyc", 32'(done_cyc), 7);
    chk("fill_done_nowr", 32'(o_write), 0);
    tick();
    chk("fill_done_pulse", 32'(done), 0);
    chk("fill_idle_ready", 32'(cmd_if.cmd_ready), 1);
    chk("fill_idle_busy", 32'(busy), 0);

    // Clipped at bottom-right corner
    send(638, 479, 10, 10, 1);
    collect(40);
    chk("clip_count", 32'(wr_addr.size()), 2);
    if (wr_addr.size() == 2) begin
      chk("clip_addr0", 32'(wr_addr[0]), 307198);
      chk("clip_addr1", 32'(wr_addr[1]), 307199);
      chk("clip_data", 32'(wr_data[1]), 1);
    end
    chk("clip_done_cyc", 32'(done_cyc), 3);
    tick();

    // Zero width
    send(5, 5, 0, 3, 2);
    chk("w0_write", 32'(o_write), 0);
    chk("w0_done", 32'(done), 1);
    chk("w0_busy", 32'(busy), 1);
    tick();
    chk("w0_done_off", 32'(done), 0);
    chk("w0_ready", 32'(cmd_if.cmd_ready), 1);

    // Off-screen x
    send(700, 5, 4, 3, 2);
    chk("x700_write", 32'(o_write), 0);
    chk("x700_done", 32'(done), 1);
    tick();
    chk("x700_done_off", 32'(done), 0);
    chk("x700_ready", 32'(cmd_if.cmd_ready), 1);

    // Pause for 4 cycles after the second pixel
    send(0, 0, 4, 1, 9);
    chk("p_w0", 32'(o_write), 1);
    chk("p_a0", 32'(o_addr), 0);
    tick();
    chk("p_w1", 32'(o_write), 1);
    chk("p_a1", 32'(o_addr), 1);
    tick();
    pause = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("p_gap_write", 32'(o_write), 0);
      chk("p_gap_addr", 32'(o_addr), 2);
      chk("p_gap_data", 32'(o_data), 9);
      chk("p_gap_done", 32'(done), 0);
      tick();
    end
    pause = 1'b0;
    #1;
    chk("p_w2", 32'(o_write), 1);
    chk("p_a2", 32'(o_addr), 2);
    tick();
    chk("p_w3", 32'(o_write), 1);
    chk("p_a3", 32'(o_addr), 3);
    tick();
    chk("p_done", 32'(done), 1);
    chk("p_done_nowr", 32'(o_write), 0);
    tick();

    // Reset during the third pixel of an 8x8 fill
    send(0, 0, 8, 8, 4);
    tick();
    tick();
    chk("r_w2", 32'(o_write), 1);
    chk("r_a2", 32'(o_addr), 2);
    RST_N = 1'b0;
    #1;
    chk("r_write", 32'(o_write), 0);
    chk("r_busy", 32'(busy), 0);
    chk("r_addr", 32'(o_addr), 0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("r_ready", 32'(cmd_if.cmd_ready), 1);
    for (int i = 0; i < 10; i++) begin
      chk("r_no_write", 32'(o_write), 0);
      chk("r_no_done", 32'(done), 0);
      tick();
    end

    // cmd_valid held high across busy; fields change after accept
    cmd_if.cmd_x     = 10'd1;
    cmd_if.cmd_y     = 9'd1;
    cmd_if.cmd_w     = 10'd2;
    cmd_if.cmd_h     = 9'd1;
    cmd_if.cmd_color = 6'd3;
    cmd_if.cmd_valid = 1'b1;
    tick();
    cmd_if.cmd_x     = 10'd5;
    cmd_if.cmd_y     = 9'd2;
    cmd_if.cmd_color = 6'd7;
    #1;
    chk("b2b_a_w0", 32'(o_write), 1);
    chk("b2b_a_a0", 32'(o_addr), 641);
    chk("b2b_a_d", 32'(o_data), 3);
    chk("b2b_a_rdy", 32'(cmd_if.cmd_ready), 0);
    tick();
    chk("b2b_a_a1", 32'(o_addr), 642);
    chk("b2b_a_d1", 32'(o_data), 3);
    tick();
    chk("b2b_a_done", 32'(done), 1);
    chk("b2b_a_rdy2", 32'(cmd_if.cmd_ready), 0);
    tick();
    chk("b2b_idle_rdy", 32'(cmd_if.cmd_ready), 1);
    chk("b2b_idle_wr", 32'(o_write), 0);
    tick();
    chk("b2b_b_w0", 32'(o_write), 1);
    chk("b2b_b_a0", 32'(o_addr), 1285);
    chk("b2b_b_d", 32'(o_data), 7);
    tick();
    cmd_if.cmd_valid = 1'b0;
    chk("b2b_b_a1", 32'(o_addr), 1286);
    tick();
    chk("b2b_b_done", 32'(done), 1);
    tick();
    chk("b2b_end_rdy", 32'(cmd_if.cmd_ready), 1);
    chk("b2b_end_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_rect_writer.md
VRAM_RECT_WRITER -- requirements
Module: vram_rect_writer

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640, visible pixel columns.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480, visible pixel rows.
REQ-003 SHALL have parameter ADDR_WIDTH, default 19, VRAM address bits.
REQ-004 SHALL have parameter DATA_WIDTH, default 6, palette-index bits per pixel.
REQ-005 SHALL have port CLK  input  1  single system clock (100 MHz); all logic on rising edge.
REQ-006 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port cmd_valid  input  1  rectangle command present.
REQ-008 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-009 SHALL have port cmd_x  input  10  left column of rectangle.
REQ-010 SHALL have port cmd_y  input  9  top row of rectangle.
REQ-011 SHALL have port cmd_w  input  10  width in pixels.
REQ-012 SHALL have port cmd_h  input  9  height in pixels.
REQ-013 SHALL have port cmd_color  input  DATA_WIDTH  palette index to fill.
REQ-014 SHALL have port pause  input  1  stall request, e.g. while the display reader owns the VRAM port.
REQ-015 SHALL have port o_addr  output  ADDR_WIDTH  VRAM write address, row-major y*SCREEN_WIDTH+x.
REQ-016 SHALL have port o_data  output  DATA_WIDTH  VRAM write data.
REQ-017 SHALL have port o_write  output  1  VRAM write strobe, one pixel per asserted cycle.
REQ-018 SHALL have port busy  output  1  command in progress.
REQ-019 SHALL have port done  output  1  one-cycle pulse marking command completion.

Function
REQ-020 SHALL implement states IDLE, FILL and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-021 SHALL accept a command on a cycle with cmd_valid=1 and cmd_ready=1, latching all cmd_* fields; cmd_* SHALL be ignored at all other times.
REQ-022 SHALL clip on accept: x_end=min(cmd_x+cmd_w, SCREEN_WIDTH), y_end=min(cmd_y+cmd_h, SCREEN_HEIGHT), with sums computed one bit wider than the operands so that no wrap occurs.
REQ-023 SHALL go IDLE->DONE with zero writes when cmd_w=0, cmd_h=0, cmd_x>=SCREEN_WIDTH or cmd_y>=SCREEN_HEIGHT; otherwise it SHALL go IDLE->FILL.
REQ-024 SHALL, in FILL, assert o_write for one pixel per non-paused cycle, in row-major order, starting at (cmd_x, cmd_y) in the cycle after accept.
REQ-025 SHALL compute o_addr incrementally as row_base + column, with row_base advancing by SCREEN_WIDTH per row and no per-pixel multiplier.
REQ-026 SHALL hold o_write=0 and all counters while pause=1; o_addr and o_data SHALL remain stable during a pause.
REQ-027 SHALL go FILL->DONE in the cycle after the write of the last pixel (x_end-1, y_end-1).
REQ-028 SHALL assert done=1 for exactly one cycle in DONE, then return to IDLE with cmd_ready=1 in the next cycle.
REQ-029 SHALL keep busy=1 in FILL and DONE and busy=0 in IDLE.
REQ-030 SHALL hold o_data equal to the latched color for the whole command.
REQ-031 SHALL hold o_write=0 outside FILL.

Reset
REQ-032 SHALL, on RST_N=0 and regardless of CLK, force state IDLE, cmd_ready=1 after deassertion, and o_write=0, busy=0, done=0, o_addr=0, o_data=0.
REQ-033 SHALL, on reset mid-FILL, abandon the command with no further writes and no done pulse.

Structure
REQ-034 SHALL take SCREEN_WIDTH, SCREEN_HEIGHT, ADDR_WIDTH and DATA_WIDTH defaults and the state encoding from the shared vram package.
REQ-035 SHALL be a single module with no sub-modules; it connects to the existing sram write port (i_addr, i_write, i_data).

Verification
REQ-036 SHALL verify: cmd (10,20,3,2,color 5) -> 6 writes at addr 12810,12811,12812,13450,13451,13452, data 5, done 7 cycles after accept.
REQ-037 SHALL verify: cmd (638,479,10,10,color 1) -> clipped to 2 writes at 307198 and 307199, then done.
REQ-038 SHALL verify: cmd_w=0 or cmd_x=700 -> no o_write, done pulses the cycle after accept, back to IDLE.
REQ-039 SHALL verify: pause=1 for 4 cycles after the 2nd pixel of (0,0,4,1) -> writes at 0,1, gap of 4 cycles, then 2,3, with addr stable during the gap.
REQ-040 SHALL verify: RST_N low during the 3rd pixel of (0,0,8,8) -> o_write=0 immediately, no done pulse, cmd_ready=1 after release.
REQ-041 SHALL verify: cmd_valid held high during busy -> second command accepted only in the IDLE cycle after done, back-to-back fills correct.
